// File: rtl/spi_slave_if_pkg.sv
// Shared definitions for the SPI slave front end: widths, FSM states,
// command opcodes and the command-routing helper.
package spi_slave_if_pkg;

    localparam int unsigned RX_W_DEF = 10;
    localparam int unsigned TX_W_DEF = 8;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CNT_MAX  = 15;

    // Opcodes carried in rx_data[9:8]
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    // Route a frame from its first bit: only the read/write bit and whether a
    // read address is pending matter; bit 8 is forwarded untouched.
    function automatic state_t route_cmd(input logic cmd_msb, input logic addr_done);
        if (cmd_msb != OP_RD_ADDR[1]) begin
            return WRITE;
        end else if (addr_done) begin
            return READ_DATA;
        end else begin
            return READ_ADD;
        end
    endfunction

endpackage

// File: rtl/spi_slave_if_if.sv
// SPI pins plus the RAM-facing rx/tx handshake of the SPI slave front end.
//   SS_n, MOSI          : serial select and data from the SPI master
//   MISO                : serial read data to the SPI master
//   rx_data, rx_valid   : received command word and its one-clk strobe
//   tx_data, tx_valid   : read byte returned by the RAM and its strobe
// slave modport is the front end's view; master modport is the far side.
interface spi_slave_if_if #(
    parameter int unsigned RX_W = spi_slave_if_pkg::RX_W_DEF,
    parameter int unsigned TX_W = spi_slave_if_pkg::TX_W_DEF
);
    logic            SS_n;
    logic            MOSI;
    logic            MISO;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic [TX_W-1:0] tx_data;
    logic            tx_valid;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_if_tx_shifter.sv
// Parallel-load, MSB-first serialiser for the read byte.
//   clk, rst_n : clock, async active-low reset
//   flush      : drop any byte in flight and force miso low
//   load       : capture data; data MSB appears on miso after this edge
//   data       : byte to serialise
//   miso       : registered serial output, 0 when idle
//   done_c     : high in the cycle whose edge retires the last bit
module spi_slave_if_tx_shifter #(
    parameter int unsigned TX_W = spi_slave_if_pkg::TX_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load,
    input  logic [TX_W-1:0] data,
    output logic            miso,
    output logic            done_c
);
    localparam int unsigned BIT_W = $clog2(TX_W);

    logic [TX_W-1:0]  sreg;
    logic [BIT_W-1:0] bit_cnt;
    logic             busy;

    // Last bit has been on miso for one clk; this edge returns miso to 0.
    assign done_c = busy && (bit_cnt == BIT_W'(TX_W - 1));

    // Shift register, bit counter and output bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            miso    <= 1'b0;
        end else if (flush) begin
            sreg    <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            miso    <= 1'b0;
        end else if (load) begin
            sreg    <= data;
            bit_cnt <= '0;
            busy    <= 1'b1;
            miso    <= data[TX_W-1];
        end else if (busy) begin
            if (done_c) begin
                busy <= 1'b0;
                miso <= 1'b0;
            end else begin
                miso    <= sreg[TX_W-2];
                sreg    <= {sreg[TX_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit command frames from MOSI into
// rx_data with a one-clk rx_valid, and on a read-data command serialises the
// RAM's returned byte onto MISO. One SPI bit per clk rising edge.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave modport (SS_n, MOSI, MISO, rx_data, rx_valid,
//                tx_data, tx_valid)
module spi_slave_if
    import spi_slave_if_pkg::*;
#(
    parameter int unsigned RX_W = RX_W_DEF,
    parameter int unsigned TX_W = TX_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_slave_if_if.slave bus
);
    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [RX_W-2:0]   shift_reg;
    logic [RX_W-1:0]   rx_data_q;
    logic              rx_valid_q;
    logic              rd_addr_done;
    logic              tx_started;
    logic              miso;
    logic              tx_done_c;

    logic              abort;
    logic              in_frame;
    logic              shift_en;
    logic              word_done;
    logic              rd_addr_set;
    logic              load_tx;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-edge control strobes
    always_comb begin
        state_next  = state;
        abort       = 1'b0;
        in_frame    = 1'b0;
        shift_en    = 1'b0;
        word_done   = 1'b0;
        rd_addr_set = 1'b0;
        load_tx     = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.SS_n) begin
                    state_next = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (bus.SS_n) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else begin
                    in_frame   = 1'b1;
                    shift_en   = 1'b1;
                    state_next = route_cmd(bus.MOSI, rd_addr_done);
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bus.SS_n) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else begin
                    in_frame = 1'b1;
                    // Bits past the command word are ignored.
                    shift_en = (bit_cnt < CNT_W'(RX_W));
                    if (bit_cnt == CNT_W'(RX_W - 1)) begin
                        word_done   = 1'b1;
                        rd_addr_set = (state == READ_ADD);
                    end
                    // RAM reply accepted only once the command word is out,
                    // and only for the first byte of the frame.
                    if ((state == READ_DATA) && (bit_cnt >= CNT_W'(RX_W)) &&
                        !tx_started && bus.tx_valid) begin
                        load_tx = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Receive datapath, read-address flag and one-byte-per-frame guard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            shift_reg    <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rd_addr_done <= 1'b0;
            tx_started   <= 1'b0;
        end else begin
            rx_valid_q <= word_done;

            if (!in_frame) begin
                bit_cnt <= '0;
            end else if (bit_cnt != CNT_W'(CNT_MAX)) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (shift_en) begin
                shift_reg <= {shift_reg[RX_W-3:0], bus.MOSI};
            end

            if (word_done) begin
                rx_data_q <= {shift_reg, bus.MOSI};
            end

            // A completed byte retires the pending read even if SS_n rises
            // on that same edge.
            if (tx_done_c) begin
                rd_addr_done <= 1'b0;
            end else if (rd_addr_set) begin
                rd_addr_done <= 1'b1;
            end

            if (!in_frame) begin
                tx_started <= 1'b0;
            end else if (load_tx) begin
                tx_started <= 1'b1;
            end
        end
    end

    spi_slave_if_tx_shifter #(
        .TX_W (TX_W)
    ) u_tx_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (abort),
        .load   (load_tx),
        .data   (bus.tx_data),
        .miso   (miso),
        .done_c (tx_done_c)
    );

    assign bus.MISO     = miso;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: received words and MISO bits are queued
// when stimulus is driven and compared as the DUT produces them.
module tb_spi_slave_if;
    import spi_slave_if_pkg::*;

    localparam int unsigned RX_W = RX_W_DEF;
    localparam int unsigned TX_W = TX_W_DEF;

    logic clk = 1'b0;
    logic rst_n;

    spi_slave_if_if #(.RX_W(RX_W), .TX_W(TX_W)) bus ();

    spi_slave_if #(.RX_W(RX_W), .TX_W(TX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [RX_W-1:0] rx_q[$];
    logic            miso_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clk; outputs sampled 1 time unit after the rising edge.
    task automatic step();
        logic exp_m;
        @(posedge clk);
        #1;
        exp_m = (miso_q.size() != 0) ? miso_q.pop_front() : 1'b0;
        check("miso", 32'(bus.MISO), 32'(exp_m));
        if (bus.rx_valid) begin
            if (rx_q.size() == 0) begin
                check("rx_valid_unexpected", 32'(1), 32'(0));
            end else begin
                check("rx_data", 32'(bus.rx_data), 32'(rx_q.pop_front()));
            end
        end
    endtask

    task automatic frame_start();
        bus.SS_n = 1'b0;
        bus.MOSI = 1'($urandom);
        step();
    endtask

    task automatic send_bits(input logic [RX_W-1:0] word, input int nbits);
        for (int i = RX_W - 1; i >= int'(RX_W) - nbits; i--) begin
            bus.MOSI = word[i];
            step();
        end
    endtask

    // Full frame; SS_n left low afterwards with one ignored extra bit.
    task automatic send_frame(input logic [RX_W-1:0] word);
        rx_q.push_back(word);
        frame_start();
        send_bits(word, RX_W);
        check("rx_valid_e10", 32'(bus.rx_valid), 32'(1));
        bus.MOSI = 1'($urandom);
        step();
        check("rx_valid_e11", 32'(bus.rx_valid), 32'(0));
    endtask

    task automatic frame_end();
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        step();
    endtask

    // RAM answer pulse; when serialisation is expected the byte is queued MSB first.
    task automatic ram_reply(input logic [TX_W-1:0] data, input bit expect_tx);
        bus.tx_data  = data;
        bus.tx_valid = 1'b1;
        if (expect_tx) begin
            for (int i = TX_W - 1; i >= 0; i--) miso_q.push_back(data[i]);
        end
        step();
        bus.tx_valid = 1'b0;
        bus.tx_data  = ~data;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        step();
        step();
        check("reset_rx_valid", 32'(bus.rx_valid), 32'(0));
        check("reset_rx_data", 32'(bus.rx_data), 32'(0));
        rst_n = 1'b1;
        step();

        // Read-data command straight after reset is treated as a read address.
        send_frame({OP_RD_DATA, 8'h3C});
        ram_reply(8'hFF, 1'b0);
        repeat (3) step();
        frame_end();
        // Now the address is pending, so the same opcode fetches data.
        send_frame({OP_RD_DATA, 8'h00});
        ram_reply(8'hC3, 1'b1);
        repeat (8) step();
        frame_end();

        // Write address / write data
        send_frame(10'h0A5);
        frame_end();
        send_frame(10'h1F0);
        frame_end();

        // Read address then read data; a second tx_valid mid-byte is ignored.
        send_frame(10'h2A5);
        frame_end();
        send_frame(10'h300);
        ram_reply(8'hF0, 1'b1);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h0F;
        step();
        bus.tx_valid = 1'b0;
        repeat (7) step();
        check("miso_after_byte", 32'(bus.MISO), 32'(0));
        frame_end();
        // Completed byte cleared the pending address: no fetch this time.
        send_frame({OP_RD_DATA, 8'h11});
        ram_reply(8'hFF, 1'b0);
        repeat (2) step();
        frame_end();

        // Abort after 5 bits, then a full frame decodes normally.
        frame_start();
        send_bits(10'h1FF, 5);
        frame_end();
        check("abort_rx_valid", 32'(bus.rx_valid), 32'(0));
        send_frame(10'h05A);
        frame_end();

        // SS_n rising exactly at the tenth bit: word discarded.
        frame_start();
        send_bits(10'h0C3, 9);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b1;
        step();
        check("ss_high_e10_rx_valid", 32'(bus.rx_valid), 32'(0));
        step();
        check("ss_high_e11_rx_valid", 32'(bus.rx_valid), 32'(0));
        send_frame(10'h0C3);
        frame_end();

        // Reset while MISO is shifting.
        send_frame(10'h255);
        frame_end();
        send_frame(10'h355);
        ram_reply(8'hA5, 1'b1);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_miso", 32'(bus.MISO), 32'(0));
        check("rst_mid_rx_valid", 32'(bus.rx_valid), 32'(0));
        miso_q.delete();
        bus.SS_n = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        // Flag cleared by reset: this frame only records the address.
        send_frame({OP_RD_DATA, 8'h77});
        ram_reply(8'hFF, 1'b0);
        repeat (2) step();
        frame_end();
        send_frame({OP_RD_DATA, 8'h77});
        ram_reply(8'h5A, 1'b1);
        repeat (8) step();
        frame_end();
        check("rx_queue_drained", 32'(rx_q.size()), 32'(0));
        check("miso_queue_drained", 32'(miso_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
